// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared definitions for the instruction-fetch stage
//
// Purpose: constants, FSM state encoding, hold-buffer layout and PC helper
// shared by if_stage and its IF/ID register.
// Ports: none (package).
package if_stage_pkg;

  localparam int XLEN = 32;

  // Default fetch start address and the bubble word (ADDI x0,x0,0).
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  // FETCH: request outstanding. HOLD: word captured while decode is stalled.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } if_state_e;

  // One-entry buffer for a word that completed while decode was stalled.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } hold_buf_t;

  // Sequential PC increment; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load/flush/hold
//
// Purpose: holds the instruction delivered to decode. flush has priority
// over load; with neither asserted the register holds its contents.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 write a bubble (NOP_INSTR, valid=0)
//   load                  capture load_instr/load_pc as a valid instruction
//   load_instr, load_pc   word and its address
//   instr, pc, pc_plus4   registered outputs to decode
//   valid                 1 = real instruction, 0 = bubble
module if_stage_if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d    = NOP_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (load) begin
      instr_d    = load_instr;
      pc_d       = load_pc;
      pc_plus4_d = pc_next(load_pc);
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32IM instruction-fetch stage with busywait memory port
//
// Purpose: owns the PC, issues instruction-memory reads, and feeds the IF/ID
// register. A one-entry hold buffer keeps a word that completes while decode
// is stalled so that nothing is lost or fetched twice.
// Ports:
//   CLK, RESET                         clock, asynchronous active-high reset
//   STALL                              hazard unit: hold IF/ID and PC
//   BRANCH_TAKEN, BRANCH_TARGET        EX-stage redirect
//   IMEM_READ, IMEM_ADDRESS            read request / word address
//   IMEM_READDATA, IMEM_BUSYWAIT       returned word / memory not ready
//   IF_ID_INSTRUCTION, IF_ID_PC,
//   IF_ID_PC_PLUS4, IF_ID_VALID        registered outputs to decode
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] IF_ID_INSTRUCTION,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC_PLUS4,
  output logic        IF_ID_VALID
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  hold_buf_t   hold_q, hold_d;

  logic        complete;
  logic        ifid_flush;
  logic        ifid_load;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  // Read is requested only in FETCH and is suppressed while reset is high.
  assign IMEM_READ    = (state_q == S_FETCH) && !RESET;
  assign IMEM_ADDRESS = pc_q;
  assign complete     = IMEM_READ && !IMEM_BUSYWAIT;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    ifid_flush = 1'b0;
    ifid_load  = 1'b0;
    ifid_instr = IMEM_READDATA;
    ifid_pc    = pc_q;

    if (BRANCH_TAKEN) begin
      // Redirect wins over everything, including STALL: any completing or
      // held word belongs to the wrong path.
      pc_d       = BRANCH_TARGET & ~32'd3;
      state_d    = S_FETCH;
      ifid_flush = 1'b1;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (complete) begin
            if (!STALL) begin
              ifid_load = 1'b1;
              pc_d      = pc_next(pc_q);
            end else begin
              hold_d.instr = IMEM_READDATA;
              hold_d.pc    = pc_q;
              state_d      = S_HOLD;
            end
          end else if (!STALL) begin
            // Decode consumed its word and nothing new arrived.
            ifid_flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            ifid_load  = 1'b1;
            ifid_instr = hold_q.instr;
            ifid_pc    = hold_q.pc;
            pc_d       = pc_next(hold_q.pc);
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  if_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (CLK),
    .rst        (RESET),
    .flush      (ifid_flush),
    .load       (ifid_load),
    .load_instr (ifid_instr),
    .load_pc    (ifid_pc),
    .instr      (IF_ID_INSTRUCTION),
    .pc         (IF_ID_PC),
    .pc_plus4   (IF_ID_PC_PLUS4),
    .valid      (IF_ID_VALID)
  );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32IM five-stage pipeline; sits directly upstream of decode (control unit, register file, sign-extend unit).
- Owns the PC, issues reads to instruction memory through a busywait handshake, and drives the IF/ID pipeline register that delivers the instruction word to decode.
- Handles hazard-unit stalls, branch/jump redirects from EX, and memory wait states. A one-entry hold buffer ensures no fetched instruction is lost or duplicated.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, bubble word (ADDI x0,x0,0) driven into IF/ID on flush/reset

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
STALL  input  1  hazard unit: hold IF/ID and PC this cycle
BRANCH_TAKEN  input  1  EX-stage redirect (taken branch, JAL, JALR)
BRANCH_TARGET  input  32  redirect address; bits [1:0] ignored, forced to 00
IMEM_READ  output  1  read request to instruction memory
IMEM_ADDRESS  output  32  fetch address (word-aligned)
IMEM_READDATA  input  32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  input  1  memory not ready; read must be held
IF_ID_INSTRUCTION  output  32  instruction to decode
IF_ID_PC  output  32  address of IF_ID_INSTRUCTION
IF_ID_PC_PLUS4  output  32  IF_ID_PC + 4 (link value for JAL/JALR)
IF_ID_VALID  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=FETCH, hold buffer empty.
  - IF_ID_INSTRUCTION=NOP_INSTR, IF_ID_PC=0, IF_ID_PC_PLUS4=0, IF_ID_VALID=0.
  - IMEM_READ forced 0 while RESET=1.
- States: FETCH (request outstanding) and HOLD (word captured, decode stalled).
- In FETCH: IMEM_READ=1 and IMEM_ADDRESS=PC. In HOLD: IMEM_READ=0.
- Completion: a rising edge with IMEM_READ=1 and IMEM_BUSYWAIT=0. Minimum latency is 1 cycle from address to IF/ID.
- Per-edge priority, highest first:
  1. BRANCH_TAKEN=1:
     - PC<=BRANCH_TARGET&~3, state<=FETCH.
     - Any completing word and any held word are discarded.
     - IF/ID<=bubble (NOP_INSTR, VALID=0). Applies regardless of STALL.
  2. FETCH, completion, STALL=0:
     - IF/ID<={READDATA, PC, PC+4, VALID=1}.
     - PC<=PC+4, stay in FETCH.
  3. FETCH, completion, STALL=1:
     - Hold buffer<={READDATA, PC}, state<=HOLD.
     - IF/ID and PC unchanged.
  4. FETCH, no completion (BUSYWAIT=1):
     - PC unchanged. IMEM_ADDRESS held stable until completion or redirect.
     - If STALL=0: IF/ID<=bubble (decode has consumed its word).
     - If STALL=1: IF/ID held.
  5. HOLD, STALL=0:
     - IF/ID<=hold buffer with VALID=1, PC<=held PC+4, state<=FETCH.
  6. HOLD, STALL=1: everything held.
- Redirect during BUSYWAIT=1:
  - The in-flight request is abandoned and IMEM_ADDRESS switches to the target next cycle.
  - Memory must accept an address change while busy. The stale data is never written to IF/ID.
- PC+4 wraps modulo 2^32: PC 32'hFFFFFFFC -> 32'h00000000, and IF_ID_PC_PLUS4 wraps the same way.
- Reset asserted mid-wait or in HOLD: the held word is lost and fetch restarts at RESET_PC after release.
- No combinational path from IMEM_READDATA to any output; IF/ID outputs are purely registered.

Decomposition:
- Shared pipeline package: NOP_INSTR constant, RESET_PC default, state encoding (FETCH=1'b0, HOLD=1'b1), IF/ID field widths.
- One natural sub-module: if_id_reg, the IF/ID register with load/flush/hold controls, reused by the pipeline top.
- PC logic and FSM stay in if_stage.

Test Plan:
- Reset then zero-wait memory returning 0x00500093, 0x00A00113 -> IF_ID sees PC 0x0 then 0x4, VALID=1, PC_PLUS4 0x4/0x8; IMEM_READ=0 while RESET=1.
- BUSYWAIT high 3 cycles on PC 0x8 -> IMEM_ADDRESS stable at 0x8; IF_ID_VALID=0 during wait; word delivered on 4th edge with IF_ID_PC=0x8.
- STALL=1 for 2 cycles at the completion of 0xC -> IF/ID holds the previous instruction; IMEM_READ=0 in HOLD; after release IF_ID_PC=0xC exactly once, next fetch at 0x10.
- BRANCH_TAKEN with target 0x103 while BUSYWAIT=1 at PC 0x20 -> stale word dropped; next IMEM_ADDRESS=0x100; IF_ID_VALID=0 for that edge.
- BRANCH_TAKEN and STALL asserted together in HOLD -> held word discarded, IF/ID=NOP_INSTR/VALID=0, PC=target.
- PC at 0xFFFFFFFC with zero-wait memory -> IF_ID_PC_PLUS4=0x0, next IMEM_ADDRESS=0x0; async RESET pulse mid-wait -> IF/ID cleared immediately, fetch resumes at RESET_PC.
